// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads the word at pc_in over a req/ack port and hands it to the decoder via valid/ready.
// Define FETCH_TIMEOUT_EN to add a memory-ack timeout that parks the unit in a sticky FAULT state.
module instr_fetch_unit #(
    parameter int PC_W        = 64,
    parameter int INSTR_W     = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               redirect,
    output logic               pc_step,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] IR_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DRAIN,
`ifdef FETCH_TIMEOUT_EN
        HOLD,
        FAULT
`else
        HOLD
`endif
    } state_t;

    state_t             state, state_nxt;
    logic [PC_W-1:0]    addr_nxt;
    logic [INSTR_W-1:0] ir_nxt;
    logic               valid_nxt;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt, to_cnt_nxt;
    logic             to_hit;
    logic             fault_nxt;

    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign fetch_fault    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        addr_nxt  = mem_addr;
        ir_nxt    = IR_out;
        valid_nxt = instr_valid;
        mem_req   = 1'b0;
        pc_step   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        fault_nxt = fetch_fault;
`endif
        case (state)
            IDLE: begin
                if (!redirect) begin
                    addr_nxt  = pc_in;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // An ack coinciding with a redirect belongs to the stale PC.
                    if (!redirect) begin
                        ir_nxt    = mem_rdata;
                        valid_nxt = 1'b1;
                        pc_step   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (to_hit) begin
                    fault_nxt = 1'b1;
                    state_nxt = FAULT;
                end
`endif
                else if (redirect) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (to_hit) begin
                    fault_nxt = 1'b1;
                    state_nxt = FAULT;
                end
`endif
            end
            HOLD: begin
                if (redirect) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end else if (instr_ready) begin
                    // PC already advanced on the ack edge, so pc_in is the next address.
                    valid_nxt = 1'b0;
                    addr_nxt  = pc_in;
                    state_nxt = REQ;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            FAULT: state_nxt = FAULT;
`endif
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    always_comb begin
        to_cnt_nxt = to_cnt;
        if ((state_nxt == REQ || state_nxt == DRAIN) && state_nxt != state) begin
            to_cnt_nxt = '0;
        end else if ((state == REQ || state == DRAIN) && !mem_ack) begin
            to_cnt_nxt = to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt      <= '0;
            fetch_fault <= 1'b0;
        end else begin
            to_cnt      <= to_cnt_nxt;
            fetch_fault <= fault_nxt;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            mem_addr    <= '0;
            IR_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_addr    <= addr_nxt;
            IR_out      <= ir_nxt;
            instr_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC model and an instruction scoreboard.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in;
    logic        redirect;
    logic        pc_step;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] IR_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    logic [63:0] pc;
    logic [63:0] redir_pc;
    logic [31:0] sb[$];
    int          checks   = 0;
    int          failures = 0;

    assign pc_in = pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(.PC_W(64), .INSTR_W(32), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .redirect    (redirect),
        .pc_step     (pc_step),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .IR_out      (IR_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_fault (fetch_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score any accept before the edge, then update the PC model after it.
    task automatic tick();
        logic step_s;
        logic red_s;
        #1;
        step_s = pc_step;
        red_s  = redirect;
        if (!reset && instr_valid && instr_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("ir_accept", 64'(IR_out), 64'(sb.pop_front()));
        end
        @(posedge clk);
        #1;
        if (red_s) pc = redir_pc;
        else if (step_s) pc = pc + 64'd4;
    endtask

    initial begin
        logic [31:0] d;
        reset       = 1'b1;
        redirect    = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        pc          = 64'h4;
        redir_pc    = '0;
        #2;
        chk("rst_req",   64'(mem_req), 64'd0);
        chk("rst_addr",  mem_addr, 64'd0);
        chk("rst_ir",    64'(IR_out), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_fault", 64'(fetch_fault), 64'd0);
        chk("rst_step",  64'(pc_step), 64'd0);

        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("first_req",  64'(mem_req), 64'd1);
        chk("first_addr", mem_addr, 64'h4);

        // Reset in the middle of a request.
        reset = 1'b1;
        #1;
        chk("midrst_req",   64'(mem_req), 64'd0);
        chk("midrst_addr",  mem_addr, 64'd0);
        chk("midrst_valid", 64'(instr_valid), 64'd0);
        tick();
        reset = 1'b0;
        chk("idle_req", 64'(mem_req), 64'd0);
        tick();
        chk("fetch_req",  64'(mem_req), 64'd1);
        chk("fetch_addr", mem_addr, 64'h4);

        // Fetch with ack after two wait cycles.
        for (int i = 0; i < 2; i++) begin
            chk("wait_step", 64'(pc_step), 64'd0);
            tick();
            chk("wait_req", 64'(mem_req), 64'd1);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h8B00_0020;
        #1;
        chk("ack_step", 64'(pc_step), 64'd1);
        sb.push_back(32'h8B00_0020);
        tick();
        mem_ack = 1'b0;
        chk("hold_valid", 64'(instr_valid), 64'd1);
        chk("hold_ir",    64'(IR_out), 64'h8B00_0020);
        chk("hold_step",  64'(pc_step), 64'd0);

        // Decoder backpressure.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 64'(instr_valid), 64'd1);
            chk("bp_ir",    64'(IR_out), 64'h8B00_0020);
            chk("bp_req",   64'(mem_req), 64'd0);
        end
        instr_ready = 1'b1;
        tick();
        chk("next_addr",  mem_addr, 64'h8);
        chk("next_req",   64'(mem_req), 64'd1);
        chk("next_valid", 64'(instr_valid), 64'd0);

        // Redirect before ack: drain the outstanding read.
        redirect = 1'b1;
        redir_pc = 64'h40;
        #1;
        chk("redir_step", 64'(pc_step), 64'd0);
        tick();
        redirect = 1'b0;
        chk("drain_req",  64'(mem_req), 64'd1);
        chk("drain_addr", mem_addr, 64'h8);
        tick();
        chk("drain_req2", 64'(mem_req), 64'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("drain_step", 64'(pc_step), 64'd0);
        tick();
        mem_ack = 1'b0;
        chk("drain_idle",  64'(mem_req), 64'd0);
        chk("drain_valid", 64'(instr_valid), 64'd0);
        tick();
        chk("redir_addr", mem_addr, 64'h40);
        chk("redir_req",  64'(mem_req), 64'd1);

        // Redirect in the same cycle as ack.
        mem_ack   = 1'b1;
        redirect  = 1'b1;
        redir_pc  = 64'h80;
        mem_rdata = 32'h1111_1111;
        #1;
        chk("ackredir_step", 64'(pc_step), 64'd0);
        tick();
        mem_ack  = 1'b0;
        redirect = 1'b0;
        chk("ackredir_valid", 64'(instr_valid), 64'd0);
        chk("ackredir_req",   64'(mem_req), 64'd0);
        tick();
        chk("ackredir_addr", mem_addr, 64'h80);

        // Redirect together with ready while holding.
        mem_ack   = 1'b1;
        mem_rdata = 32'h2222_2222;
        #1;
        chk("hr_step", 64'(pc_step), 64'd1);
        sb.push_back(32'h2222_2222);
        tick();
        mem_ack = 1'b0;
        chk("hr_valid", 64'(instr_valid), 64'd1);
        redirect = 1'b1;
        redir_pc = 64'h100;
        tick();
        redirect = 1'b0;
        chk("hr_valid_drop", 64'(instr_valid), 64'd0);
        chk("hr_idle",       64'(mem_req), 64'd0);
        tick();
        chk("hr_addr", mem_addr, 64'h100);

        // Back-to-back fetches, one-cycle ack, ready held high.
        for (int i = 0; i < 4; i++) begin
            d         = $urandom;
            mem_ack   = 1'b1;
            mem_rdata = d;
            sb.push_back(d);
            tick();
            mem_ack = 1'b0;
            chk("b2b_valid", 64'(instr_valid), 64'd1);
            tick();
            chk("b2b_addr", mem_addr, 64'h100 + 64'(4 * (i + 1)));
        end

        // No ack ever arrives.
        for (int k = 1; k <= 20; k++) begin
            tick();
`ifdef FETCH_TIMEOUT_EN
            chk("to_req",   64'(mem_req), 64'(k < 16));
            chk("to_fault", 64'(fetch_fault), 64'(k >= 16));
`else
            chk("to_req",   64'(mem_req), 64'd1);
            chk("to_fault", 64'(fetch_fault), 64'd0);
`endif
        end
        reset = 1'b1;
        #1;
        chk("end_fault", 64'(fetch_fault), 64'd0);
        chk("end_req",   64'(mem_req), 64'd0);
        chk("sb_empty",  64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
